// File: rtl/btn_debounce_edge.sv
// Debounces one raw, asynchronous push-button or switch input into the clk domain.
// Publishes a clean level, one-cycle rise/fall pulses, a toggle bit and a press counter.
module btn_debounce_edge #(
  parameter int CNT_MAX = 20,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             toggle_q,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             btn_level_q, btn_level_d;
  logic             rise_pulse_q, rise_pulse_d;
  logic             fall_pulse_q, fall_pulse_d;
  logic             toggle_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    s1_d         = btn_in;
    s2_d         = s1_q;
    state_d      = state_q;
    cnt_d        = '0;
    btn_level_d  = btn_level_q;
    rise_pulse_d = 1'b0;
    fall_pulse_d = 1'b0;
    toggle_d     = toggle_q;
    press_cnt_d  = press_cnt_q;

    unique case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = PEND_HI;
          cnt_d   = CW'(1);
        end
      end
      PEND_HI: begin
        // Any low sample drops back and discards the partial count.
        if (!s2_q) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = STABLE_HI;
          btn_level_d  = 1'b1;
          rise_pulse_d = 1'b1;
          toggle_d     = ~toggle_q;
          press_cnt_d  = press_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = PEND_LO;
          cnt_d   = CW'(1);
        end
      end
      PEND_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = STABLE_LO;
          btn_level_d  = 1'b0;
          fall_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= STABLE_LO;
      cnt_q        <= '0;
      btn_level_q  <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      toggle_q     <= 1'b0;
      press_cnt_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_level_q  <= btn_level_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      toggle_q     <= toggle_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign press_cnt  = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench for btn_debounce_edge: three instances cover CNT_MAX=20,
// CNT_MAX=4 and a narrow CNT_W=3/CNT_MAX=2 counter for wrap-around.
module tb_btn_debounce_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst20, btn20, lvl20, rise20, fall20, tog20;
  logic [7:0] cnt20;
  logic       rst4, btn4, lvl4, rise4, fall4, tog4;
  logic [7:0] cnt4;
  logic       rst2, btn2, lvl2, rise2, fall2, tog2;
  logic [2:0] cnt2;

  btn_debounce_edge #(.CNT_MAX(20), .CNT_W(8)) u_d20 (
    .clk(clk), .rst_n(rst20), .btn_in(btn20), .btn_level(lvl20),
    .rise_pulse(rise20), .fall_pulse(fall20), .toggle_q(tog20), .press_cnt(cnt20)
  );
  btn_debounce_edge #(.CNT_MAX(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst_n(rst4), .btn_in(btn4), .btn_level(lvl4),
    .rise_pulse(rise4), .fall_pulse(fall4), .toggle_q(tog4), .press_cnt(cnt4)
  );
  btn_debounce_edge #(.CNT_MAX(2), .CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst2), .btn_in(btn2), .btn_level(lvl2),
    .rise_pulse(rise2), .fall_pulse(fall2), .toggle_q(tog2), .press_cnt(cnt2)
  );

  int passed = 0;
  int total  = 0;
  int nrise20 = 0, nrise4 = 0, nfall4 = 0, nboth = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, sample 1 time unit later and accumulate pulse counts.
  task automatic tick();
    @(posedge clk);
    #1;
    nrise20 += int'(rise20);
    nrise4  += int'(rise4);
    nfall4  += int'(fall4);
    if ((rise4 && fall4) || (rise20 && fall20) || (rise2 && fall2)) nboth++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst20 = 1'b0; rst4 = 1'b0; rst2 = 1'b0;
    btn20 = 1'b1; btn4 = 1'b0; btn2 = 1'b0;

    // 1. Reset with input held high, then a fresh press after release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs20", {lvl20, rise20, fall20, tog20, cnt20}, 32'h0);
    end
    check("rst_outs4", {lvl4, rise4, fall4, tog4, cnt4}, 32'h0);
    check("rst_outs2", {lvl2, rise2, fall2, tog2, cnt2}, 32'h0);
    rst20 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    nrise20 = 0;
    ticks(21);
    check("rst_hold_no_early_rise", 32'(nrise20), 32'd0);
    check("rst_hold_lvl_before", 32'(lvl20), 32'd0);
    tick();
    check("rst_hold_rise_at22", 32'(rise20), 32'd1);
    check("rst_hold_lvl_at22", 32'(lvl20), 32'd1);
    tick();
    check("rst_hold_rise_width", 32'(rise20), 32'd0);
    ticks(5);
    check("rst_hold_rise_once", 32'(nrise20), 32'd1);
    check("rst_hold_press_cnt", 32'(cnt20), 32'd1);
    check("rst_hold_toggle", 32'(tog20), 32'd1);

    // 2. Clean press and release, CNT_MAX=4.
    nrise4 = 0; nfall4 = 0;
    btn4 = 1'b1;
    ticks(5);
    check("clean_no_early_rise", 32'(nrise4), 32'd0);
    check("clean_lvl_early", 32'(lvl4), 32'd0);
    tick();
    check("clean_rise", 32'(rise4), 32'd1);
    check("clean_lvl", 32'(lvl4), 32'd1);
    check("clean_press_cnt", 32'(cnt4), 32'd1);
    tick();
    check("clean_rise_width", 32'(rise4), 32'd0);
    check("clean_lvl_held", 32'(lvl4), 32'd1);
    ticks(3);
    btn4 = 1'b0;
    ticks(5);
    check("clean_no_early_fall", 32'(nfall4), 32'd0);
    tick();
    check("clean_fall", 32'(fall4), 32'd1);
    check("clean_lvl_low", 32'(lvl4), 32'd0);
    check("clean_press_kept", 32'(cnt4), 32'd1);
    tick();
    check("clean_fall_width", 32'(fall4), 32'd0);

    // 3. Bounce pattern: longest high run is 3 < CNT_MAX.
    nrise4 = 0; nfall4 = 0;
    begin
      logic [8:0] pat;
      pat = 9'b101110110;
      for (int i = 8; i >= 0; i--) begin
        btn4 = pat[i];
        tick();
      end
    end
    btn4 = 1'b0;
    ticks(8);
    check("bounce_no_rise", 32'(nrise4), 32'd0);
    check("bounce_no_fall", 32'(nfall4), 32'd0);
    check("bounce_lvl", 32'(lvl4), 32'd0);
    check("bounce_press_kept", 32'(cnt4), 32'd1);

    // 4. Threshold: 3-cycle run rejected, 4-cycle run accepted.
    nrise4 = 0; nfall4 = 0;
    btn4 = 1'b1; ticks(3);
    btn4 = 1'b0; ticks(8);
    check("thr3_no_rise", 32'(nrise4), 32'd0);
    btn4 = 1'b1; ticks(4);
    btn4 = 1'b0; ticks(10);
    check("thr4_one_rise", 32'(nrise4), 32'd1);
    check("thr4_one_fall", 32'(nfall4), 32'd1);
    check("thr4_press_cnt", 32'(cnt4), 32'd2);
    check("thr4_toggle", 32'(tog4), 32'd0);
    check("thr4_lvl", 32'(lvl4), 32'd0);

    // 5. Wrap of a 3-bit press counter over 9 presses.
    for (int i = 1; i <= 9; i++) begin
      btn2 = 1'b1; ticks(6);
      btn2 = 1'b0; ticks(6);
      check($sformatf("wrap_press_%0d", i), 32'(cnt2), 32'(i % 8));
    end
    check("wrap_toggle", 32'(tog2), 32'd1);

    // 6. Reset on the acceptance edge wins; rise re-accepted 6 edges later.
    nrise4 = 0;
    btn4 = 1'b1;
    ticks(5);
    rst4 = 1'b0;
    tick();
    check("midrst_outs", {lvl4, rise4, fall4, tog4, cnt4}, 32'h0);
    check("midrst_no_rise", 32'(nrise4), 32'd0);
    rst4 = 1'b1;
    ticks(5);
    check("midrst_no_early_rise", 32'(nrise4), 32'd0);
    tick();
    check("midrst_rise", 32'(rise4), 32'd1);
    check("midrst_press_cnt", 32'(cnt4), 32'd1);
    check("midrst_toggle", 32'(tog4), 32'd1);
    tick();
    check("midrst_rise_width", 32'(rise4), 32'd0);

    check("pulses_never_together", 32'(nboth), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
